// File: rtl/dmem_load_ctrl.sv
// Data memory with a loader front end: LOAD fills words from a beat stream,
// RUN serves the core (read-first, latency 1), CLEAR scrubs the array to zero.
module dmem_load_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned BYTE_ADDR = 1,
  parameter int unsigned SKIP_LOAD = 0
) (
  input  logic              clk,
  input  logic              reset_x,
  input  logic              qed_rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              core_rst_n,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              core_we,
  output logic [DATA_W-1:0] core_rdata,
  output logic              loaded,
  output logic              busy,
  output logic              oob_err
);

  localparam int unsigned IW  = $clog2(DEPTH);
  localparam int unsigned LSB = (BYTE_ADDR != 0) ? 2 : 0;
  localparam int unsigned TOP = IW + LSB;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam state_t RST_STATE = (SKIP_LOAD != 0) ? RUN : LOAD;

  state_t            state;
  state_t            state_next;
  logic [IW-1:0]     clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IW-1:0]     core_idx;
  logic              core_oob;
  logic              mem_we;
  logic [IW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Address decode, single write-port steering and next-state selection
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    core_idx   = IW'(core_addr >> LSB);
    core_oob   = (core_addr >> TOP) != '0;

    case (state)
      LOAD: begin
        if (ld_valid && ld_ready) begin
          mem_we    = 1'b1;
          mem_waddr = IW'(ld_addr);
          mem_wdata = ld_data;
          if (ld_last) state_next = RUN;
        end
      end
      RUN: begin
        if (core_we && !core_oob) begin
          mem_we    = 1'b1;
          mem_waddr = core_idx;
          mem_wdata = core_wdata;
        end
        if (qed_rst) state_next = CLEAR;
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt;
        if (clr_cnt == IW'(DEPTH - 1)) state_next = RUN;
      end
      default: state_next = LOAD;
    endcase
  end

  // State and registered outputs; status outputs track the upcoming state
  always_ff @(posedge clk) begin
    if (!reset_x) begin
      state      <= RST_STATE;
      clr_cnt    <= '0;
      core_rdata <= '0;
      oob_err    <= 1'b0;
      loaded     <= 1'b0;
      core_rst_n <= 1'b0;
      ld_ready   <= 1'b0;
      busy       <= (SKIP_LOAD == 0);
    end else begin
      state      <= state_next;
      clr_cnt    <= (state == CLEAR) ? clr_cnt + IW'(1) : '0;
      ld_ready   <= (state_next == LOAD);
      busy       <= (state_next != RUN);
      core_rst_n <= (state_next == RUN);
      loaded     <= loaded | (state_next == RUN);
      core_rdata <= (state == RUN && !core_oob) ? mem[core_idx] : '0;
      if (state == RUN && core_oob) oob_err <= 1'b1;
    end
  end

  // Memory array is never reset; writes are blocked while reset is held
  always_ff @(posedge clk) begin
    if (reset_x && mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_dmem_load_ctrl.sv
// Scoreboard bench for dmem_load_ctrl: a driver pushes expected read data from
// a word-array model, a negedge monitor pops and compares core_rdata.
module tb_dmem_load_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned DEP = 16;

  logic          clk = 1'b0;
  logic          reset_x, qed_rst, s_qed_rst;
  logic          ld_valid, ld_last;
  logic [AW-1:0] ld_addr, core_addr;
  logic [DW-1:0] ld_data, core_wdata;
  logic          core_we;

  logic          ld_ready, core_rst_n, loaded, busy, oob_err;
  logic [DW-1:0] core_rdata;
  logic          s_ld_ready, s_core_rst_n, s_loaded, s_busy, s_oob_err;
  logic [DW-1:0] s_core_rdata;

  always #5 clk = ~clk;

  dmem_load_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .BYTE_ADDR(1), .SKIP_LOAD(0)) dut (
    .clk(clk), .reset_x(reset_x), .qed_rst(qed_rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .core_rst_n(core_rst_n), .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
    .core_rdata(core_rdata), .loaded(loaded), .busy(busy), .oob_err(oob_err)
  );

  dmem_load_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .BYTE_ADDR(1), .SKIP_LOAD(1)) dut_skip (
    .clk(clk), .reset_x(reset_x), .qed_rst(s_qed_rst),
    .ld_valid(ld_valid), .ld_ready(s_ld_ready), .ld_addr(ld_addr), .ld_data(ld_data), .ld_last(ld_last),
    .core_rst_n(s_core_rst_n), .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
    .core_rdata(s_core_rdata), .loaded(s_loaded), .busy(s_busy), .oob_err(s_oob_err)
  );

  typedef struct {
    int unsigned due;
    logic [DW-1:0] exp;
    bit care;
  } sb_t;

  sb_t           sb_q[$];
  int unsigned   checks = 0;
  int unsigned   failures = 0;
  int unsigned   cyc = 0;
  logic [DW-1:0] model_mem [DEP];
  bit            known [DEP];
  bit            exp_oob;
  bit            s_ready_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare registered read data in the cycle it is due
  always @(negedge clk) begin
    sb_t e;
    while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      if (e.care) check("core_rdata", core_rdata, e.exp);
    end
    if (s_ld_ready) s_ready_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One core access in RUN; the model is a plain word array with read-before-write
  task automatic core_op(input logic [31:0] addr, input bit we, input logic [31:0] wd, input bit qed);
    int unsigned idx;
    bit oob;
    sb_t e;
    oob   = addr >= 4 * DEP;
    idx   = (addr / 4) % DEP;
    e.due = cyc + 1;
    e.exp = oob ? '0 : model_mem[idx];
    e.care = oob || known[idx];
    if (we && !oob) begin
      model_mem[idx] = wd;
      known[idx] = 1'b1;
    end
    if (oob) exp_oob = 1'b1;
    sb_q.push_back(e);
    core_addr = addr; core_we = we; core_wdata = wd; qed_rst = qed;
    tick();
    core_we = 1'b0; qed_rst = 1'b0;
    check("oob_err", 32'(oob_err), 32'(exp_oob));
  endtask

  task automatic ld_beat(input int unsigned a, input logic [31:0] d, input bit last);
    int unsigned n;
    n = 0;
    ld_valid = 1'b1; ld_addr = 32'(a); ld_data = d; ld_last = last;
    while (!ld_ready && n < 20) begin
      tick();
      n++;
    end
    check("ld_ready_wait", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    model_mem[a] = d;
    known[a] = 1'b1;
  endtask

  task automatic do_reset();
    reset_x = 1'b0;
    tick();
    tick();
    reset_x = 1'b1;
    exp_oob = 1'b0;
  endtask

  initial begin
    int unsigned n, bad;
    logic [31:0] a, d0, d1;
    reset_x = 1'b0; qed_rst = 1'b0; s_qed_rst = 1'b0;
    ld_valid = 1'b0; ld_last = 1'b0; ld_addr = '0; ld_data = '0;
    core_addr = '0; core_wdata = '0; core_we = 1'b0;
    exp_oob = 1'b0;
    for (int i = 0; i < DEP; i++) known[i] = 1'b0;

    tick(); tick();
    check("rst_ld_ready", 32'(ld_ready), 0);
    check("rst_core_rst_n", 32'(core_rst_n), 0);
    check("rst_loaded", 32'(loaded), 0);
    check("rst_oob_err", 32'(oob_err), 0);
    check("rst_core_rdata", core_rdata, 0);
    check("rst_busy", 32'(busy), 1);
    check("skip_rst_core_rst_n", 32'(s_core_rst_n), 0);
    reset_x = 1'b1;
    tick();
    check("skip_core_rst_n_after_reset", 32'(s_core_rst_n), 1);
    check("skip_loaded_after_reset", 32'(s_loaded), 1);
    check("load_ld_ready", 32'(ld_ready), 1);

    // Four-beat load of 0x11..0x44, then read byte address 0x8
    for (int i = 0; i < 4; i++) ld_beat(i, 32'h11 * 32'(i + 1), i == 3);
    check("post_load_ld_ready", 32'(ld_ready), 0);
    check("post_load_core_rst_n", 32'(core_rst_n), 1);
    check("post_load_loaded", 32'(loaded), 1);
    check("post_load_busy", 32'(busy), 0);
    core_op(32'h8, 1'b0, '0, 1'b0);

    // Read-first behaviour on a same-cycle write
    core_op(32'h10, 1'b1, 32'h55, 1'b0);
    core_op(32'h10, 1'b1, 32'hDEADBEEF, 1'b0);
    core_op(32'h10, 1'b0, '0, 1'b0);

    // Out-of-range write must not alias onto word 0
    core_op(32'h1000, 1'b1, 32'hCAFEF00D, 1'b0);
    core_op(32'h0, 1'b0, '0, 1'b0);

    repeat (80) begin
      if ($urandom_range(0, 9) == 0) a = 32'(64 + $urandom_range(0, 4095));
      else a = 32'($urandom_range(0, 63));
      core_op(a, 1'($urandom_range(0, 1)), $urandom, 1'b0);
    end

    // Scrub: length fixed at DEP cycles, a second request does not extend it
    core_op(32'($urandom_range(0, 63)), 1'b1, $urandom, 1'b1);
    n = 0; bad = 0;
    while (busy && n < 40) begin
      if (core_rst_n) bad++;
      if (n == 3) check("rdata_in_clear", core_rdata, 0);
      qed_rst = (n == 5);
      core_we = 1'b1; core_addr = 32'($urandom_range(0, 63)); core_wdata = $urandom;
      tick();
      n++;
    end
    core_we = 1'b0; qed_rst = 1'b0;
    check("clear_cycles", 32'(n), 32'(DEP));
    check("clear_core_rst_n_low", 32'(bad), 0);
    check("post_clear_core_rst_n", 32'(core_rst_n), 1);
    check("post_clear_loaded", 32'(loaded), 1);
    for (int i = 0; i < DEP; i++) begin
      model_mem[i] = '0;
      known[i] = 1'b1;
    end
    for (int i = 0; i < DEP; i++) core_op(32'(i * 4), 1'b0, '0, 1'b0);

    // Reset abandons a load part-way; written words survive
    do_reset();
    check("rst2_loaded", 32'(loaded), 0);
    check("rst2_busy", 32'(busy), 1);
    check("rst2_oob_err", 32'(oob_err), 0);
    d0 = $urandom; d1 = $urandom;
    ld_beat(0, d0, 1'b0);
    ld_beat(1, d1, 1'b0);
    do_reset();
    check("abort_loaded", 32'(loaded), 0);
    check("abort_core_rst_n", 32'(core_rst_n), 0);
    ld_beat(2, $urandom, 1'b0);
    ld_beat(3, $urandom, 1'b1);
    for (int i = 0; i < 6; i++) core_op(32'(i * 4), 1'b0, '0, 1'b0);

    n = 0;
    while (sb_q.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    check("sb_drain", 32'(sb_q.size()), 0);
    check("skip_ld_ready_never", 32'(s_ready_seen), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
